if_id_pipe: RTL and testbench

IF_ID_PIPE -- requirements
Module: if_id_pipe

---
 rtl/if_id_pipe_pkg.sv | 18 +
 rtl/if_id_pipe_if.sv | 38 +++
 rtl/if_id_pipe_sat_counter.sv | 32 +++
 rtl/if_id_pipe.sv | 141 ++++++++++++++
 tb/tb_if_id_pipe.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/if_id_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_pipe_pkg
// Brief   : Shared IF/ID pipeline types: skid-buffer states and bubble encoding.
// Rev     : 1.0  initial release
// ============================================================================
package if_id_pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   localparam logic [31:0] c_NOP_INST = 32'h0000_0000;

endpackage : if_id_pipe_pkg
`default_nettype wire

// File: rtl/if_id_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : if_id_pipe_if
// Brief   : IF-to-ID handshake bundle; slave is the pipe, master drives it.
// Rev     : 1.0  initial release
// ============================================================================
interface if_id_pipe_if #(
   parameter int LANES  = 1,
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = 16
);
   logic                    in_valid_i;
   logic                    in_ready_o;
   logic [PC_W-1:0]         pc_i;
   logic [LANES*INST_W-1:0] inst_i;
   logic [LANES-1:0]        lane_valid_i;
   logic                    out_valid_o;
   logic                    out_ready_i;
   logic [PC_W-1:0]         pc_o;
   logic [LANES*INST_W-1:0] inst_o;
   logic [LANES-1:0]        lane_valid_o;
   logic                    flush_i;
   logic                    cnt_clr_i;
   logic [CNT_W-1:0]        stall_cnt_o;

   modport slave (
      input  in_valid_i, pc_i, inst_i, lane_valid_i, out_ready_i, flush_i, cnt_clr_i,
      output in_ready_o, out_valid_o, pc_o, inst_o, lane_valid_o, stall_cnt_o
   );

   modport master (
      output in_valid_i, pc_i, inst_i, lane_valid_i, out_ready_i, flush_i, cnt_clr_i,
      input  in_ready_o, out_valid_o, pc_o, inst_o, lane_valid_o, stall_cnt_o
   );

endinterface : if_id_pipe_if
`default_nettype wire

// File: rtl/if_id_pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Saturating up-counter with clear taking priority over increment.
// Rev     : 1.0  initial release
// ============================================================================
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_clr,
   input  wire logic             i_inc,
   output logic      [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/if_id_pipe.sv
`default_nettype none
// ============================================================================
// Module  : if_id_pipe
// Brief   : IF/ID two-entry skid buffer with flush, bubble insertion, stall count.
// Rev     : 1.0  initial release
// ============================================================================
module if_id_pipe
   import if_id_pipe_pkg::*;
#(
   parameter int                LANES    = 1,
   parameter int                PC_W     = 32,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(c_NOP_INST),
   parameter int                CNT_W    = 16
) (
   input wire logic    clk_i,
   input wire logic    rst_i,
   if_id_pipe_if.slave bus
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    w_load_main_in;
   logic                    w_load_main_skid;
   logic                    w_load_skid;
   logic                    r_in_ready;
   logic                    w_out_valid;
   logic                    w_stall_inc;
   logic [CNT_W-1:0]        w_stall_cnt;

   logic [PC_W-1:0]         r_main_pc;
   logic [LANES*INST_W-1:0] r_main_inst;
   logic [LANES-1:0]        r_main_lv;
   logic [PC_W-1:0]         r_skid_pc;
   logic [LANES*INST_W-1:0] r_skid_inst;
   logic [LANES-1:0]        r_skid_lv;

   logic [LANES*INST_W-1:0] w_in_inst;
   logic [LANES*INST_W-1:0] w_out_inst;

   assign w_out_valid = (r_state != ST_EMPTY);

   // Invalid lanes become bubbles on entry; an empty buffer shows bubbles everywhere.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_in_inst[k*INST_W +: INST_W]  = bus.lane_valid_i[k] ? bus.inst_i[k*INST_W +: INST_W]
                                                                  : NOP_INST;
      assign w_out_inst[k*INST_W +: INST_W] = w_out_valid ? r_main_inst[k*INST_W +: INST_W]
                                                          : NOP_INST;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (bus.flush_i) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (bus.in_valid_i) begin
                  w_state_nxt    = ST_FULL;
                  w_load_main_in = 1'b1;
               end
            end
            ST_FULL: begin
               if (bus.out_ready_i) begin
                  if (bus.in_valid_i) begin
                     w_load_main_in = 1'b1;
                  end else begin
                     w_state_nxt = ST_EMPTY;
                  end
               end else if (bus.in_valid_i) begin
                  w_state_nxt = ST_SKID;
                  w_load_skid = 1'b1;
               end
            end
            ST_SKID: begin
               if (bus.out_ready_i) begin
                  w_state_nxt      = ST_FULL;
                  w_load_main_skid = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_main_pc   <= '0;
         r_main_inst <= {LANES{NOP_INST}};
         r_main_lv   <= '0;
         r_skid_pc   <= '0;
         r_skid_inst <= {LANES{NOP_INST}};
         r_skid_lv   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_SKID);
         if (w_load_main_in) begin
            r_main_pc   <= bus.pc_i;
            r_main_inst <= w_in_inst;
            r_main_lv   <= bus.lane_valid_i;
         end else if (w_load_main_skid) begin
            r_main_pc   <= r_skid_pc;
            r_main_inst <= r_skid_inst;
            r_main_lv   <= r_skid_lv;
         end
         if (w_load_skid) begin
            r_skid_pc   <= bus.pc_i;
            r_skid_inst <= w_in_inst;
            r_skid_lv   <= bus.lane_valid_i;
         end
      end
   end

   assign w_stall_inc = w_out_valid && !bus.out_ready_i && !bus.flush_i;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .i_clr (bus.cnt_clr_i),
      .i_inc (w_stall_inc),
      .o_cnt (w_stall_cnt)
   );

   assign bus.in_ready_o   = r_in_ready;
   assign bus.out_valid_o  = w_out_valid;
   assign bus.pc_o         = r_main_pc;
   assign bus.inst_o       = w_out_inst;
   assign bus.lane_valid_o = w_out_valid ? r_main_lv : '0;
   assign bus.stall_cnt_o  = w_stall_cnt;

endmodule : if_id_pipe
`default_nettype wire

// File: tb/tb_if_id_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_id_pipe
// Brief   : Directed self-checking bench for if_id_pipe (2 lanes, 4-bit counter).
// Rev     : 1.0  initial release
// ============================================================================
module tb_if_id_pipe;

   localparam int          LANES  = 2;
   localparam int          PC_W   = 32;
   localparam int          INST_W = 32;
   localparam int          CNT_W  = 4;
   localparam logic [31:0] NOP    = 32'hCAFE_0013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   if_id_pipe_if #(.LANES(LANES), .PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) bus ();

   if_id_pipe #(
      .LANES    (LANES),
      .PC_W     (PC_W),
      .INST_W   (INST_W),
      .NOP_INST (NOP),
      .CNT_W    (CNT_W)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid_i   = 1'b1;
      bus.pc_i         = 32'hDEAD_0000;
      bus.inst_i       = {32'h1111_1111, 32'h2222_2222};
      bus.lane_valid_i = 2'b11;
      bus.out_ready_i  = 1'b0;
      bus.flush_i      = 1'b0;
      bus.cnt_clr_i    = 1'b0;
      tick();
      tick();
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o); end
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.pc_o); end
      checks++; if (bus.inst_o !== {NOP, NOP}) begin errors++; $display("FAIL reset_inst: got %h want %h", bus.inst_o, {NOP, NOP}); end
      checks++; if (bus.lane_valid_o !== 2'b00) begin errors++; $display("FAIL reset_lane_valid: got %b want 00", bus.lane_valid_o); end
      checks++; if (bus.stall_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt_o); end
   endtask

   task automatic test_single();
      rst = 1'b0;
      bus.in_valid_i   = 1'b1;
      bus.pc_i         = 32'h100;
      bus.inst_i       = {32'h1111_1111, 32'h00A0_0093};
      bus.lane_valid_i = 2'b11;
      bus.out_ready_i  = 1'b1;
      tick();
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.out_valid_o); end
      checks++; if (bus.pc_o !== 32'h100) begin errors++; $display("FAIL single_pc: got %h want 100", bus.pc_o); end
      checks++; if (bus.inst_o[31:0] !== 32'h00A0_0093) begin errors++; $display("FAIL single_inst: got %h want 00a00093", bus.inst_o[31:0]); end
      checks++; if (bus.lane_valid_o !== 2'b11) begin errors++; $display("FAIL single_lv: got %b want 11", bus.lane_valid_o); end
   endtask

   task automatic test_skid();
      bus.out_ready_i = 1'b0;
      bus.in_valid_i  = 1'b1;
      bus.pc_i        = 32'h104;
      bus.inst_i      = {32'h3333_3333, 32'h00B0_0113};
      tick();
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL skid_in_ready: got %b want 0", bus.in_ready_o); end
      checks++; if (bus.pc_o !== 32'h100) begin errors++; $display("FAIL skid_hold_pc: got %h want 100", bus.pc_o); end
      bus.in_valid_i = 1'b0;
      tick();
      tick();
      checks++; if (bus.stall_cnt_o !== 4'd3) begin errors++; $display("FAIL skid_cnt: got %0d want 3", bus.stall_cnt_o); end
      checks++; if (bus.inst_o[31:0] !== 32'h00A0_0093) begin errors++; $display("FAIL skid_hold_inst: got %h want 00a00093", bus.inst_o[31:0]); end
      bus.out_ready_i = 1'b1;
      tick();
      checks++; if (bus.pc_o !== 32'h104) begin errors++; $display("FAIL skid_release_pc: got %h want 104", bus.pc_o); end
      checks++; if (bus.inst_o[31:0] !== 32'h00B0_0113) begin errors++; $display("FAIL skid_release_inst: got %h want 00b00113", bus.inst_o[31:0]); end
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL skid_release_ready: got %b want 1", bus.in_ready_o); end
      tick();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.pc_o !== 32'h104) begin errors++; $display("FAIL drain_pc_hold: got %h want 104", bus.pc_o); end
      checks++; if (bus.inst_o !== {NOP, NOP}) begin errors++; $display("FAIL drain_inst: got %h want %h", bus.inst_o, {NOP, NOP}); end
      checks++; if (bus.stall_cnt_o !== 4'd3) begin errors++; $display("FAIL drain_cnt: got %0d want 3", bus.stall_cnt_o); end
   endtask

   task automatic test_flush();
      bus.out_ready_i = 1'b0;
      bus.in_valid_i  = 1'b1;
      bus.pc_i        = 32'h200;
      tick();
      bus.pc_i = 32'h204;
      tick();
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL flush_pre_skid: got %b want 0", bus.in_ready_o); end
      bus.flush_i = 1'b1;
      bus.pc_i    = 32'h208;
      tick();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.inst_o !== {NOP, NOP}) begin errors++; $display("FAIL flush_inst: got %h want %h", bus.inst_o, {NOP, NOP}); end
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", bus.in_ready_o); end
      checks++; if (bus.lane_valid_o !== 2'b00) begin errors++; $display("FAIL flush_lv: got %b want 00", bus.lane_valid_o); end
      checks++; if (bus.stall_cnt_o !== 4'd4) begin errors++; $display("FAIL flush_cnt: got %0d want 4", bus.stall_cnt_o); end
      bus.flush_i     = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      tick();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_emit: got %b want 0", bus.out_valid_o); end
      bus.in_valid_i = 1'b1;
      bus.pc_i       = 32'h300;
      tick();
      bus.flush_i = 1'b1;
      bus.pc_i    = 32'h304;
      tick();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_full_drop: got %b want 0", bus.out_valid_o); end
      bus.flush_i    = 1'b0;
      bus.in_valid_i = 1'b0;
      tick();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_full_no_emit: got %b want 0", bus.out_valid_o); end
   endtask

   task automatic test_lanes();
      bus.out_ready_i  = 1'b1;
      bus.in_valid_i   = 1'b1;
      bus.pc_i         = 32'h340;
      bus.inst_i       = {32'h1234_5678, 32'h0000_0013};
      bus.lane_valid_i = 2'b01;
      tick();
      checks++; if (bus.inst_o !== {NOP, 32'h0000_0013}) begin errors++; $display("FAIL lanes_01_inst: got %h want %h", bus.inst_o, {NOP, 32'h0000_0013}); end
      checks++; if (bus.lane_valid_o !== 2'b01) begin errors++; $display("FAIL lanes_01_lv: got %b want 01", bus.lane_valid_o); end
      bus.lane_valid_i = 2'b10;
      tick();
      checks++; if (bus.inst_o !== {32'h1234_5678, NOP}) begin errors++; $display("FAIL lanes_10_inst: got %h want %h", bus.inst_o, {32'h1234_5678, NOP}); end
      checks++; if (bus.lane_valid_o !== 2'b10) begin errors++; $display("FAIL lanes_10_lv: got %b want 10", bus.lane_valid_o); end
      bus.in_valid_i   = 1'b0;
      bus.lane_valid_i = 2'b11;
      tick();
   endtask

   task automatic test_back_to_back();
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid_i = 1'b1;
         bus.pc_i       = 32'h400 + 32'(4 * i);
         bus.inst_i     = {32'hFFFF_0000, 32'h0400_0000 + 32'(i)};
         tick();
         checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.out_valid_o); end
         checks++; if (bus.pc_o !== 32'h400 + 32'(4 * i)) begin errors++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, bus.pc_o, 32'h400 + 32'(4 * i)); end
         checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.in_ready_o); end
      end
      bus.in_valid_i = 1'b0;
      tick();
   endtask

   task automatic test_saturate();
      bus.cnt_clr_i = 1'b1;
      tick();
      checks++; if (bus.stall_cnt_o !== 4'd0) begin errors++; $display("FAIL sat_clear: got %0d want 0", bus.stall_cnt_o); end
      bus.cnt_clr_i   = 1'b0;
      bus.in_valid_i  = 1'b1;
      bus.pc_i        = 32'h500;
      bus.out_ready_i = 1'b0;
      tick();
      bus.in_valid_i = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      checks++; if (bus.stall_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_max: got %0d want 15", bus.stall_cnt_o); end
      bus.cnt_clr_i = 1'b1;
      tick();
      checks++; if (bus.stall_cnt_o !== 4'd0) begin errors++; $display("FAIL sat_clr_prio: got %0d want 0", bus.stall_cnt_o); end
      bus.cnt_clr_i = 1'b0;
      tick();
      checks++; if (bus.stall_cnt_o !== 4'd1) begin errors++; $display("FAIL sat_resume: got %0d want 1", bus.stall_cnt_o); end
   endtask

   task automatic test_reset_mid();
      bus.in_valid_i = 1'b1;
      bus.pc_i       = 32'h600;
      tick();
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL rmid_pre_skid: got %b want 0", bus.in_ready_o); end
      rst           = 1'b1;
      bus.flush_i   = 1'b1;
      bus.cnt_clr_i = 1'b1;
      tick();
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", bus.in_ready_o); end
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL rmid_pc: got %h want 0", bus.pc_o); end
      checks++; if (bus.inst_o !== {NOP, NOP}) begin errors++; $display("FAIL rmid_inst: got %h want %h", bus.inst_o, {NOP, NOP}); end
      checks++; if (bus.lane_valid_o !== 2'b00) begin errors++; $display("FAIL rmid_lv: got %b want 00", bus.lane_valid_o); end
      checks++; if (bus.stall_cnt_o !== 4'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", bus.stall_cnt_o); end
      rst            = 1'b0;
      bus.flush_i    = 1'b0;
      bus.cnt_clr_i  = 1'b0;
      bus.in_valid_i = 1'b0;
      tick();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_after: got %b want 0", bus.out_valid_o); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_skid();
      test_flush();
      test_lanes();
      test_back_to_back();
      test_saturate();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_if_id_pipe
`default_nettype wire
